// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read-side arbiter.
// Holds the arbiter state encoding, default sizes and width helpers.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_DSIZE    = 8;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_MAXBURST = 4;

    // Width needed to encode n distinct values, never below one bit.
    function automatic int width_for(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Burst counter must hold 0..maxburst.
    function automatic int cnt_width(input int maxburst);
        return width_for(maxburst + 1);
    endfunction

    // Round-robin pointer holds 0..nreq-1.
    function automatic int ptr_width(input int nreq);
        return width_for(nreq);
    endfunction

    localparam int CNTW = cnt_width(DEF_MAXBURST);
    localparam int PTRW = ptr_width(DEF_NREQ);

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or
// after ptr (wrapping modulo NREQ) as both a one-hot vector and an index.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PTRW = ptr_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PTRW-1:0] idx,
    output logic            found
);

    int              cand;
    logic [PTRW-1:0] cand_idx;

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = PTRW'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign onehot[gi] = found && (idx == PTRW'(gi));
        end
    endgenerate

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side scheduler sharing one async-FIFO read port among NREQ consumers.
// Round-robin grants, each burst bounded to MAXBURST words, one idle bubble
// between bursts. Optional macro FIFO_RD_ARB_LOCK_EN adds a lock input that
// lets the granted consumer keep reading past MAXBURST.
module fifo_rd_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int DSIZE    = DEF_DSIZE,
    parameter int MAXBURST = DEF_MAXBURST
) (
`ifdef FIFO_RD_ARB_LOCK_EN
    input  logic [NREQ-1:0]  lock,
`endif
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [NREQ-1:0]  gnt,
    output logic [DSIZE-1:0] dout,
    output logic [NREQ-1:0]  dvalid
);

    localparam int CNTW_L = cnt_width(MAXBURST);
    localparam int PTRW_L = ptr_width(NREQ);

    arb_state_t         state_reg, state_next;
    logic [NREQ-1:0]    gnt_reg, gnt_next;
    logic [PTRW_L-1:0]  gidx_reg, gidx_next;
    logic [CNTW_L-1:0]  cnt_reg, cnt_next;
    logic [PTRW_L-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [DSIZE-1:0]   dout_reg, dout_next;
    logic [NREQ-1:0]    dvalid_reg, dvalid_next;

    logic [NREQ-1:0]    pick_onehot;
    logic [PTRW_L-1:0]  pick_idx;
    logic               pick_found;
    logic               req_g;
    logic               lock_g;
    logic               at_limit;
    logic               burst_exit;
    logic [PTRW_L-1:0]  ptr_after_g;

    rr_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW_L)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // Request and lock of the current owner only; zero when nobody is granted.
    assign req_g = |(req & gnt_reg);
`ifdef FIFO_RD_ARB_LOCK_EN
    assign lock_g = |(lock & gnt_reg);
`else
    assign lock_g = 1'b0;
`endif

    assign at_limit    = (cnt_reg >= CNTW_L'(MAXBURST - 1));
    assign ptr_after_g = (gidx_reg == PTRW_L'(NREQ - 1)) ? '0 : gidx_reg + PTRW_L'(1);

    // Next-state, read strobe and datapath decisions.
    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        gidx_next   = gidx_reg;
        cnt_next    = cnt_reg;
        rr_ptr_next = rr_ptr_reg;
        dout_next   = dout_reg;
        dvalid_next = '0;
        rinc        = 1'b0;
        burst_exit  = 1'b0;
        case (state_reg)
            IDLE: begin
                // Never grant into an empty FIFO.
                if (pick_found && !rempty) begin
                    state_next = BURST;
                    gnt_next   = pick_onehot;
                    gidx_next  = pick_idx;
                    cnt_next   = '0;
                end
            end
            BURST: begin
                rinc = req_g & ~rempty;
                if (rinc) begin
                    dout_next   = rdata;
                    dvalid_next = gnt_reg;
                    // Saturate so a locked burst cannot wrap the counter.
                    if (cnt_reg != CNTW_L'(MAXBURST)) begin
                        cnt_next = cnt_reg + CNTW_L'(1);
                    end
                end
                burst_exit = (rinc && at_limit && !lock_g) || !req_g || (rempty && !rinc);
                if (burst_exit) begin
                    state_next  = IDLE;
                    gnt_next    = '0;
                    rr_ptr_next = ptr_after_g;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // State and output registers; async reset clears everything at once.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg  <= IDLE;
            gnt_reg    <= '0;
            gidx_reg   <= '0;
            cnt_reg    <= '0;
            rr_ptr_reg <= '0;
            dout_reg   <= '0;
            dvalid_reg <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            gidx_reg   <= gidx_next;
            cnt_reg    <= cnt_next;
            rr_ptr_reg <= rr_ptr_next;
            dout_reg   <= dout_next;
            dvalid_reg <= dvalid_next;
        end
    end

    assign gnt    = gnt_reg;
    assign dout   = dout_reg;
    assign dvalid = dvalid_reg;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a tiny FIFO read-side model.
// FIFO word k holds 8'hA0 + k; rempty is rd_ptr == wr_ptr.
module tb_fifo_rd_arbiter;

    logic       rclk;
    logic       rrst_n;
    logic [3:0] req;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic [3:0] gnt;
    logic [7:0] dout;
    logic [3:0] dvalid;
    logic [3:0] lock;

    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;

    int total = 0;
    int bad   = 0;

    fifo_rd_arbiter #(
        .NREQ     (4),
        .DSIZE    (8),
        .MAXBURST (4)
    ) dut (
`ifdef FIFO_RD_ARB_LOCK_EN
        .lock   (lock),
`endif
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .req    (req),
        .rempty (rempty),
        .rdata  (rdata),
        .rinc   (rinc),
        .gnt    (gnt),
        .dout   (dout),
        .dvalid (dvalid)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO read-side model: pointer advances on each rinc edge.
    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = 8'hA0 + rd_ptr;
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) rd_ptr <= 8'd0;
        else if (rinc) rd_ptr <= rd_ptr + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end else begin
            $display("chk %s ok val=%0h", tag, obs);
        end
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        req    = 4'b0000;
        lock   = 4'b0000;
        wr_ptr = 8'd0;
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    int   gseq[$];
    int   dvcnt[4];
    int   nread;
    logic [3:0] prev_gnt;

    initial begin
        logic [3:0] e_gnt  [9];
        logic       e_rinc [9];
        logic [3:0] e_dv   [9];
        logic [7:0] e_dout [9];
        int         e_seq  [5];

        e_gnt  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
        e_rinc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        e_dv   = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
        e_dout = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'hA4, 8'hA5, 8'hA5};
        e_seq  = '{0, 1, 2, 3, 0};

        // Reset state.
        do_reset();
        check("rst_gnt", gnt, 4'h0);
        check("rst_dvalid", dvalid, 4'h0);
        check("rst_dout", dout, 8'h00);
        check("rst_rinc", rinc, 1'b0);

        // Single requester, 6 words: burst of 4, bubble, burst of 2, exit on empty.
        wr_ptr = 8'd6;
        req    = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            @(negedge rclk);
            check($sformatf("t1_gnt_c%0d", k + 1), gnt, e_gnt[k]);
            check($sformatf("t1_rinc_c%0d", k + 1), rinc, e_rinc[k]);
            check($sformatf("t1_dv_c%0d", k + 1), dvalid, e_dv[k]);
            check($sformatf("t1_dout_c%0d", k + 1), dout, e_dout[k]);
        end

        // All requesters, FIFO never empty: grants 0,1,2,3,0 with 4 words each.
        do_reset();
        wr_ptr   = 8'd200;
        req      = 4'b1111;
        prev_gnt = 4'h0;
        nread    = 0;
        gseq.delete();
        for (int r = 0; r < 4; r++) dvcnt[r] = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge rclk);
            check($sformatf("t2_onehot_c%0d", k + 1), ($countones(gnt) <= 1), 1);
            if (gnt != 4'h0 && prev_gnt == 4'h0) begin
                for (int r = 0; r < 4; r++) if (gnt[r]) gseq.push_back(r);
            end
            if (dvalid != 4'h0) begin
                check($sformatf("t2_dout_w%0d", nread), dout, 8'(8'hA0 + nread));
                nread++;
                for (int r = 0; r < 4; r++) if (dvalid[r]) dvcnt[r]++;
            end
            prev_gnt = gnt;
        end
        check("t2_ngrants", gseq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gseq.size()) check($sformatf("t2_order%0d", i), gseq[i], e_seq[i]);
            else check($sformatf("t2_order%0d", i), 32'hFFFF_FFFF, e_seq[i]);
        end
        check("t2_dv0", dvcnt[0], 8);
        check("t2_dv1", dvcnt[1], 4);
        check("t2_dv2", dvcnt[2], 4);
        check("t2_dv3", dvcnt[3], 4);

        // Empty gating: no grant or read while empty; grant the cycle after data arrives.
        do_reset();
        req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge rclk);
            check($sformatf("t3_gnt_empty%0d", k), gnt, 4'h0);
            check($sformatf("t3_rinc_empty%0d", k), rinc, 1'b0);
        end
        wr_ptr = 8'd3;
        @(negedge rclk);
        check("t3_gnt", gnt, 4'b0010);
        check("t3_rinc", rinc, 1'b1);
        @(negedge rclk);
        check("t3_dv", dvalid, 4'b0010);
        check("t3_dout", dout, 8'hA0);

        // Requester 2 drops req after two reads; next grant starts at 3.
        do_reset();
        wr_ptr = 8'd50;
        req    = 4'b0100;
        @(negedge rclk);
        check("t4_gnt", gnt, 4'b0100);
        @(negedge rclk);
        check("t4_dv1", dvalid, 4'b0100);
        check("t4_dout1", dout, 8'hA0);
        @(negedge rclk);
        check("t4_dv2", dvalid, 4'b0100);
        check("t4_dout2", dout, 8'hA1);
        req = 4'b0000;
        #1;
        check("t4_rinc_drop", rinc, 1'b0);
        @(negedge rclk);
        check("t4_gnt_idle", gnt, 4'h0);
        check("t4_dv_idle", dvalid, 4'h0);
        check("t4_reads", rd_ptr, 8'd2);
        req = 4'b1111;
        @(negedge rclk);
        check("t4_next_gnt", gnt, 4'b1000);

        // Async reset in the middle of a burst.
        do_reset();
        wr_ptr = 8'd50;
        req    = 4'b0010;
        @(negedge rclk);
        check("t5_gnt", gnt, 4'b0010);
        @(negedge rclk);
        @(negedge rclk);
        check("t5_dout2", dout, 8'hA1);
        #2;
        rrst_n = 1'b0;
        #1;
        check("t5_rst_gnt", gnt, 4'h0);
        check("t5_rst_dv", dvalid, 4'h0);
        check("t5_rst_dout", dout, 8'h00);
        check("t5_rst_rinc", rinc, 1'b0);
        @(negedge rclk);
        rrst_n = 1'b1;
        req    = 4'b1111;
        wr_ptr = 8'd50;
        @(negedge rclk);
        check("t5_first_gnt", gnt, 4'b0001);

`ifdef FIFO_RD_ARB_LOCK_EN
        // Locked burst: ten reads without rotation, then rotate after lock drops.
        do_reset();
        wr_ptr = 8'd50;
        req    = 4'b0010;
        lock   = 4'b0010;
        @(negedge rclk);
        check("t6_gnt", gnt, 4'b0010);
        req = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            @(negedge rclk);
            check($sformatf("t6_gnt_r%0d", k), gnt, 4'b0010);
            check($sformatf("t6_dout_r%0d", k), dout, 8'(8'hA0 + k));
        end
        lock = 4'b0000;
        @(negedge rclk);
        check("t6_unlock_gnt", gnt, 4'h0);
        check("t6_unlock_dout", dout, 8'hAA);
        @(negedge rclk);
        check("t6_rotate_gnt", gnt, 4'b0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
Name: fifo_rd_arbiter

Overview:
- Read-side scheduler for the async FIFO. Shares the FIFO's single read port (rinc/rdata/rempty, rclk domain) among NREQ consumers.
- Round-robin arbitration with bounded bursts: a granted consumer drains up to MAXBURST words, then ownership rotates.
- Sits directly beside the FIFO read pointer/empty logic and drives its rinc; the FIFO memory read (rdata) is combinational from raddr.

Parameters:
- NREQ, 4, number of consumers (2..8).
- DSIZE, 8, FIFO data width.
- MAXBURST, 4, maximum words per grant (1..15).

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-consumer read request; level, held while the consumer wants data.
- rempty  in  1  FIFO empty flag (registered, from the read-pointer block).
- rdata  in  DSIZE  FIFO read data at the current raddr.
- rinc  out  1  FIFO read increment; combinational.
- gnt  out  NREQ  registered one-hot grant; all zero when idle.
- dout  out  DSIZE  registered data delivered to the granted consumer.
- dvalid  out  NREQ  registered one-hot strobe: dout is valid for that consumer this cycle.

Behaviour:
- Reset (async, rrst_n=0): state=IDLE, gnt=0, dvalid=0, dout=0, burst count=0, rr pointer=0 (requester 0 has highest priority first). rinc=0 while gnt=0.
- States:
  - IDLE: if |req and !rempty, grant the first requester at or after the rr pointer (wrapping modulo NREQ). Next cycle: gnt=onehot, cnt=0, state=BURST. If rempty, stay in IDLE (no grant to an empty FIFO).
  - BURST: rinc = req[g] & ~rempty. On each rinc edge: cnt+1, dout<=rdata, dvalid<=onehot(g). Data latency is 1 rclk from the rinc edge.
  - BURST -> IDLE when any of the following holds; rr pointer <= g+1 mod NREQ and gnt=0 next cycle:
    - (a) rinc and cnt==MAXBURST-1;
    - (b) req[g]==0;
    - (c) rempty while rinc=0.
- Exactly one rinc per cycle max. rinc never asserted while rempty=1 (double guard with the FIFO's own rempty gating).
- After IDLE is re-entered, the next grant takes effect at the earliest 1 cycle later. There is one idle bubble between bursts.
- dvalid deasserts the cycle after the last rinc. Consumers must not rely on gnt alone to sample dout.
- req[g] dropped in the same cycle as the last allowed read: the read still occurs only if req[g]=1 at that edge. A dropped req means no read.
- Requesters requesting simultaneously are served strictly in rr order; no starvation. Worst-case wait is (NREQ-1)*(MAXBURST+1) cycles of FIFO non-empty.
- cnt width: clog2(MAXBURST+1). rr pointer width: clog2(NREQ), with explicit wrap (no power-of-two assumption).
- Reset mid-burst: all outputs clear immediately. The word in flight is lost to the consumer but remains consumed in the FIFO only if the rinc edge completed before reset.

Optional Feature:
- Macro FIFO_RD_ARB_LOCK_EN.
- Defined:
  - Adds input lock[NREQ-1:0].
  - While lock[g]=1, condition (a) is suppressed: the burst continues past MAXBURST, and cnt saturates at MAXBURST.
  - Exits via (b)/(c) or lock drop. Lock is ignored for non-granted requesters.
- Undefined: no lock port; bursts are always bounded by MAXBURST.

Decomposition:
- Shared package fifo_pkg: arbiter state enum (IDLE, BURST), localparam width helpers (clog2-based CNTW, PTRW), default DSIZE.
- One natural sub-module: rr_pick. Combinational round-robin priority picker: inputs req and rr pointer, outputs a one-hot grant and its index.

Test Plan:
- Single requester: req=4'b0001, 6 words in FIFO, MAXBURST=4 -> 4 rinc pulses, dvalid[0] x4 with data D0..D3, one idle cycle, regrant, D4..D5, then exit on rempty.
- All requesters: req=4'b1111, FIFO kept non-empty -> grant order 0,1,2,3,0; 4 words each; gnt never multi-hot.
- Empty gating: req=4'b0010, rempty=1 -> gnt stays 0, rinc=0. Deassert rempty -> gnt=4'b0010 the next cycle, then rinc.
- Mid-burst req drop: requester 2 granted, drops req after 2 reads -> exactly 2 dvalid[2], IDLE, rr pointer=3.
- Async reset mid-burst: pull rrst_n low at read 2 -> gnt/dvalid/dout=0 immediately. After release, requester 0 is granted first.
- FIFO_RD_ARB_LOCK_EN defined: lock[1]=1, req[1]=1, 10 words -> 10 consecutive reads without rotation. Lock drop -> rotates after the current cycle.
